// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Computes one product or quotient bit per cycle and holds busy for the hazard unit.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             startin,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dbz;
  logic             r_neg_res;
  logic             r_neg_rem;
  // r_acc: product high half / partial remainder; r_lowq: multiplier / quotient
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lowq;
  logic [WIDTH-1:0] r_opb;

  logic               w_signed;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_signed = ~op[0];
    w_b_zero = (b == '0);
    w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
    w_addend = r_lowq[0] ? r_opb : {WIDTH{1'b0}};
    w_msum   = {1'b0, r_acc} + {1'b0, w_addend};
    // Restoring step: keep the trial difference only when it did not go negative.
    w_shift  = {r_acc, r_lowq[WIDTH-1]};
    w_trial  = w_shift - {1'b0, r_opb};
    w_fits   = ~w_trial[WIDTH];
    w_prod   = r_neg_res ? -{r_acc, r_lowq} : {r_acc, r_lowq};
    w_quo    = r_neg_res ? -r_lowq : r_lowq;
    w_rem    = r_neg_rem ? -r_acc : r_acc;
  end

  // NOTE: every register here uses non-blocking assignments so all state
  // updates at an edge see the same pre-edge values.
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      // NOTE: datapath registers are reset too, keeping simulation X-free
      // and a discarded operation fully cleared.
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_dbz     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_lowq    <= '0;
      r_opb     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start && !flush) begin
            r_is_div  <= op[1];
            r_dbz     <= op[1] && w_b_zero;
            r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_signed && a[WIDTH-1];
            r_cnt     <= CW'(WIDTH - 1);
            r_acc     <= '0;
            r_opb     <= op[1] ? w_b_mag : w_a_mag;
            // Divide-by-zero keeps the raw dividend so it can be returned in HI.
            if (op[1]) r_lowq <= w_b_zero ? a : w_a_mag;
            else       r_lowq <= w_b_mag;
            busy      <= 1'b1;
            r_state   <= (op[1] && w_b_zero) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_acc  <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
              r_lowq <= {r_lowq[WIDTH-2:0], w_fits};
            end else begin
              r_acc  <= w_msum[WIDTH:1];
              r_lowq <= {w_msum[0], r_lowq[WIDTH-1:1]};
            end
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (r_dbz) begin
              hi <= r_lowq;
              lo <= '1;
            end else if (r_is_div) begin
              hi <= w_rem;
              lo <= w_quo;
            end else begin
              hi <= w_prod[2*WIDTH-1:WIDTH];
              lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 32-bit instance for the main scenarios and an
// 8-bit instance for narrow-width arithmetic and asynchronous reset.
module tb_mdu_iter;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32 = 1'b1, start = 1'b0, flush = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wr_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        rst8 = 1'b1, start8 = 1'b0, flush8 = 1'b0, wr_hi8 = 1'b0, wr_lo8 = 1'b0;
  logic [1:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, wr_data8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .startin(rst32), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .startin(rst8), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  function automatic logic [63:0] model32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint q, r, p;
    logic [63:0] u;
    case (o)
      OP_MULT:  begin p = sx * sy; return p[63:0]; end
      OP_MULTU: begin u = {32'b0, x} * {32'b0, y}; return u; end
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy; r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [15:0] model8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int q, r, p;
    logic [15:0] u;
    case (o)
      OP_MULT:  begin p = sx * sy; return p[15:0]; end
      OP_MULTU: begin u = {8'b0, x} * {8'b0, y}; return u; end
      OP_DIV: begin
        if (y == 0) return {x, 8'hFF};
        q = sx / sy; r = sx % sy;
        return {r[7:0], q[7:0]};
      end
      default: begin
        if (y == 0) return {x, 8'hFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called #1 after an edge; returns #1 after the start edge E.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    op = o; a = x; b = y; start = 1'b1;
    if (push) q32.push_back(model32(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int n = 0;
    int nb = busy ? 1 : 0;
    logic [63:0] exp;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
    exp = q32.pop_front();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: no done within %0d edges", name, n);
    end else begin
      if (n != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d edges, want %0d", name, n, exp_lat);
      end
      n_tests++;
      if (nb != exp_lat) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d, want %0d", name, nb, exp_lat);
      end
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
      end
      n_tests++;
      if ({hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL %s hi_lo: got %h_%h, want %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
      end
    end
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input bit push);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    if (push) q8.push_back(model8(o, x, y));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait8(input string name, input int exp_lat);
    int n = 0;
    logic [15:0] exp;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    exp = q8.pop_front();
    n_tests++;
    if (!done8 || n != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges (done=%b), want %0d", name, n, done8, exp_lat);
    end
    n_tests++;
    if ({hi8, lo8} !== exp) begin
      n_fail++;
      $display("FAIL %s hi_lo: got %h_%h, want %h_%h", name, hi8, lo8, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic count_done(input string name, input int cycles);
    int pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL %s stray_done: got %0d pulses, want 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    #2; rst32 = 1'b0; rst8 = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, hi, lo} !== '0 || {busy8, done8, hi8, lo8} !== '0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    @(posedge clk); @(posedge clk); #1;
    rst32 = 1'b1; rst8 = 1'b1;
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_result("mult_neg", 33);
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_done_width: got done=%b one cycle later, want 0", done);
    end
    issue(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("mult_minneg", 33);
    for (int i = 0; i < 3; i++) begin
      logic [1:0] o = 2'($urandom_range(0, 3));
      issue(o, $urandom, $urandom, 1'b1);
      wait_result("rand_op", 33);
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_result("multu_max", 33);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
    wait_result("divu_b2b", 33);
  endtask

  task automatic test_signed_div();
    issue(OP_DIV, -32'sd7, 32'd2, 1'b1);
    wait_result("div_neg", 33);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("div_overflow", 33);
    issue(OP_DIV, 32'd7, -32'sd2, 1'b1);
    wait_result("div_neg_divisor", 33);
  endtask

  task automatic test_div_zero();
    issue(OP_DIV, 32'h1234, 32'd0, 1'b1);
    wait_result("div_zero", 1);
    issue(OP_DIVU, 32'h8000_0001, 32'd0, 1'b1);
    wait_result("divu_zero", 1);
    wr_hi = 1'b1; wr_data = 32'hAAAA;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    cur_hi = 32'hAAAA;
    n_tests++;
    if (hi !== cur_hi || lo !== cur_lo || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: got hi=%h lo=%h done=%b, want hi=%h lo=%h done=0", hi, lo, done, cur_hi, cur_lo);
    end
  endtask

  task automatic test_busy_ignore();
    issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
    wr_lo = 1'b1; wr_data = 32'h5555;
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    wr_lo = 1'b0; start = 1'b0;
    n_tests++;
    if (lo !== cur_lo) begin
      n_fail++;
      $display("FAIL mtlo_busy: got lo=%h, want %h", lo, cur_lo);
    end
    wait_result("start_while_busy", 32);
    count_done("start_while_busy", 40);
  endtask

  task automatic test_flush();
    issue(OP_MULT, 32'd5, 32'd6, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== cur_hi || lo !== cur_lo) begin
      n_fail++;
      $display("FAIL flush_calc: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
               busy, done, hi, lo, cur_hi, cur_lo);
    end
    count_done("flush_calc", 40);
    flush = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_width8();
    issue8(OP_DIV, 8'h80, 8'd3, 1'b1);
    wait8("w8_div", 9);
    issue8(OP_MULTU, 8'hFF, 8'hFF, 1'b1);
    wait8("w8_multu", 9);
    issue8(OP_MULT, 8'd5, 8'd6, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #3; rst8 = 1'b0;
    #1;
    n_tests++;
    if ({busy8, done8, hi8, lo8} !== '0) begin
      n_fail++;
      $display("FAIL w8_async_reset: got busy=%b done=%b hi=%h lo=%h, want all 0", busy8, done8, hi8, lo8);
    end
    @(posedge clk); #1;
    rst8 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_signed_div();
    test_div_zero();
    test_busy_ignore();
    test_flush();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core's EX stage. It executes MULT, MULTU, DIV and DIVU over WIDTH cycles, one bit per cycle, and holds `busy` so the hazard logic can stall dependent instructions. It also supports direct HI/LO writes (MTHI/MTLO) and an abort input driven by branch and flush logic.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `startin`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; accepted only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`, `b`  in  WIDTH  operands (rs, rt); sampled with `start`.
- `flush`  in  1  abort any operation in progress.
- `wr_hi`, `wr_lo`  in  1  MTHI/MTLO strobes.
- `wr_data`  in  WIDTH  data for `wr_hi`/`wr_lo`.
- `busy`  out  1  operation in progress; drives the hazard unit's PC/IF_ID stall.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1:
  - Latch operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - Latch the result sign and remainder sign.
  - Load counter = WIDTH−1.
  - Go to CALC, except for divide with `b`=0, which goes directly to FIX with the div-by-zero flag set.
- CALC multiply: shift-add on a 2·WIDTH product register, one multiplier bit per cycle.
- CALC divide: restoring division, one quotient bit per cycle; remainder is WIDTH+1 bits internally.
- CALC counts down. At counter 0 it goes to FIX.
- FIX:
  - Apply two's-complement sign correction:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Write HI/LO: product high→`hi`, low→`lo`; remainder→`hi`, quotient→`lo`.
  - Pulse `done`; go to IDLE.
- Divide by zero: `hi`=`a` (unmodified), `lo`=all ones, for both signed and unsigned.
- Signed overflow (most-negative / −1): `lo`=most-negative value, `hi`=0; no exception.
- `busy`=1 in CALC and FIX.
- `start` while `busy`=1 is ignored; there is no queuing.
- `wr_hi`/`wr_lo` act only in IDLE and are ignored while `busy`=1.
  - In IDLE with both `start` and `wr_*` asserted, the write takes effect at that edge; the operation's FIX later overwrites HI/LO.
- `flush`=1 in CALC or FIX: go to IDLE at the next edge. HI/LO are unchanged and `done` is not pulsed.
- `flush` has priority over FIX.
- `flush` in IDLE blocks a same-cycle `start`.
- All arithmetic is WIDTH-parametric; no constant assumes 32.

## Timing
- Reset (`startin`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - Reset mid-operation discards the operation.
  - Outputs go to reset values immediately, without waiting for a clock edge.
- Start sampled at edge E: `busy`=1 from E until the result edge.
- Normal operation: CALC at edges E+1 … E+WIDTH; FIX executes at edge E+WIDTH+1.
  - After that edge `hi`/`lo` are valid, `done`=1 for exactly one cycle, and `busy`=0.
  - Total: WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Divide by zero: FIX at E+1; `done` after edge E+1.
- Back-to-back: a `start` in the `done` cycle is accepted, because the state is IDLE.
- `wr_hi`/`wr_lo` in IDLE update `hi`/`lo` at the same edge; `done` is not pulsed.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then MULT `a`=0xFFFFFFFD, `b`=7, WIDTH=32 → after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `done` is high for one cycle; `busy` is high for 33 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then DIVU 100/7 issued in the `done` cycle → `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV `a`=0x1234, `b`=0 → `done` after 1 edge, `hi`=0x1234, `lo`=0xFFFFFFFF. Then MTHI 0xAAAA in IDLE → `hi`=0xAAAA. MTLO while busy → ignored.
- Start MULT 5×6, assert `flush` at CALC cycle 10 → `busy` falls next edge, `done` never pulses, HI/LO keep prior values. `start` during `busy` is ignored.
- WIDTH=8 build: DIV −128/3 → `lo`=0xD6, `hi`=0xFE. MULTU 0xFF×0xFF → `hi`=0xFE, `lo`=0x01 after 9 edges. Async reset mid-CALC → all outputs 0 immediately.
